// File: rtl/circle_points_stream.sv
// Midpoint-circle generator with 8-way symmetry. Streams points over a
// valid/ready handshake and can optionally drop duplicates within a group.
`default_nettype none

module circle_points_stream #(
  parameter int WIDTH = 32,
  parameter int DEDUP = 0
) (
  input  logic             _clock,
  input  logic             _reset_n,
  input  logic             _start,
  input  logic [WIDTH-1:0] s_x,
  input  logic [WIDTH-1:0] s_y,
  input  logic [WIDTH-1:0] radius,
  input  logic             _ready,
  output logic             _valid,
  output logic [WIDTH-1:0] _out0,
  output logic [WIDTH-1:0] _out1,
  output logic             _busy,
  output logic             _done
);

  localparam int DW = WIDTH + 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [DW-1:0]    d_q, d_d;
  logic [2:0]       k_q, k_d;

  logic [WIDTH-1:0] px [8];
  logic [WIDTH-1:0] py [8];
  logic             dup;
  logic             adv;
  logic [DW-1:0]    xe, ye, re;

  assign xe = {{4{x_q[WIDTH-1]}}, x_q};
  assign ye = {{4{y_q[WIDTH-1]}}, y_q};
  assign re = {{4{radius[WIDTH-1]}}, radius};

  // The eight symmetric points of the current (x, y), in emission order.
  always_comb begin
    px[0] = cx_q + x_q;  py[0] = cy_q + y_q;
    px[1] = cx_q + x_q;  py[1] = cy_q - y_q;
    px[2] = cx_q - x_q;  py[2] = cy_q + y_q;
    px[3] = cx_q - x_q;  py[3] = cy_q - y_q;
    px[4] = cx_q + y_q;  py[4] = cy_q + x_q;
    px[5] = cx_q + y_q;  py[5] = cy_q - x_q;
    px[6] = cx_q - y_q;  py[6] = cy_q + x_q;
    px[7] = cx_q - y_q;  py[7] = cy_q - x_q;
  end

  always_comb begin
    dup = 1'b0;
    if (DEDUP != 0) begin
      for (int j = 0; j < 7; j++) begin
        if ((3'(j) < k_q) && (px[j] == px[k_q]) && (py[j] == py[k_q])) dup = 1'b1;
      end
    end
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state_q <= S_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      d_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      d_q     <= d_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    x_d     = x_q;
    y_d     = y_q;
    d_d     = d_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (_start) begin
          state_d = S_EMIT;
          cx_d    = s_x;
          cy_d    = s_y;
          x_d     = '0;
          y_d     = radius;
          d_d     = DW'(3) - (re << 1);
          k_d     = '0;
        end
      end
      S_EMIT: begin
        if (adv) begin
          if (k_q == 3'd7) state_d = ($signed(y_q) >= $signed(x_q)) ? S_STEP : S_DONE;
          else             k_d     = k_q + 3'd1;
        end
      end
      S_STEP: begin
        x_d = x_q + WIDTH'(1);
        // (x+1)-(y-1) folds to x-y+2 on the pre-step values.
        if ($signed(d_q) > 0) begin
          y_d = y_q - WIDTH'(1);
          d_d = d_q + ((xe - ye + DW'(2)) << 2) + DW'(10);
        end else begin
          d_d = d_q + ((xe + DW'(1)) << 2) + DW'(6);
        end
        k_d     = '0;
        state_d = S_EMIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    _valid = (state_q == S_EMIT) && !dup;
    adv    = (state_q == S_EMIT) && (dup || _ready);
    _out0  = (state_q == S_EMIT) ? px[k_q] : '0;
    _out1  = (state_q == S_EMIT) ? py[k_q] : '0;
    _busy  = (state_q == S_EMIT) || (state_q == S_STEP);
    _done  = (state_q == S_DONE);
  end

endmodule

`default_nettype wire

// File: tb/tb_circle_points_stream.sv
// Randomised scoreboard bench for circle_points_stream (32-bit plain, 32-bit
// dedup and 8-bit wrap instances).
`default_nettype none

module tb_circle_points_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, ready;
  logic [31:0] cx, cy, r;
  logic        start8;
  logic [7:0]  cx8, cy8, r8;

  logic        va, vb, vc, busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [31:0] oa0, oa1, ob0, ob1;
  logic [7:0]  oc0, oc1;

  logic [63:0] qa[$], qb[$], qc[$];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  circle_points_stream #(.WIDTH(32), .DEDUP(0)) dut_a (
    ._clock(clk), ._reset_n(rst_n), ._start(start), .s_x(cx), .s_y(cy), .radius(r),
    ._ready(ready), ._valid(va), ._out0(oa0), ._out1(oa1), ._busy(busy_a), ._done(done_a));

  circle_points_stream #(.WIDTH(32), .DEDUP(1)) dut_b (
    ._clock(clk), ._reset_n(rst_n), ._start(start), .s_x(cx), .s_y(cy), .radius(r),
    ._ready(ready), ._valid(vb), ._out0(ob0), ._out1(ob1), ._busy(busy_b), ._done(done_b));

  circle_points_stream #(.WIDTH(8), .DEDUP(0)) dut_c (
    ._clock(clk), ._reset_n(rst_n), ._start(start8), .s_x(cx8), .s_y(cy8), .radius(r8),
    ._ready(ready), ._valid(vc), ._out0(oc0), ._out1(oc1), ._busy(busy_c), ._done(done_c));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: walk the midpoint recurrence and list every emitted point.
  task automatic model(input longint cx0, input longint cy0, input longint r0,
                       input int w, input bit dd, input int id);
    longint x, y, d, m;
    longint gx[8], gy[8];
    bit dupe;
    logic [63:0] v;
    m = (longint'(1) << w) - 1;
    x = 0; y = r0; d = 3 - 2 * r0;
    forever begin
      gx[0] = cx0 + x; gy[0] = cy0 + y;
      gx[1] = cx0 + x; gy[1] = cy0 - y;
      gx[2] = cx0 - x; gy[2] = cy0 + y;
      gx[3] = cx0 - x; gy[3] = cy0 - y;
      gx[4] = cx0 + y; gy[4] = cy0 + x;
      gx[5] = cx0 + y; gy[5] = cy0 - x;
      gx[6] = cx0 - y; gy[6] = cy0 + x;
      gx[7] = cx0 - y; gy[7] = cy0 - x;
      for (int k = 0; k < 8; k++) begin
        dupe = 1'b0;
        if (dd) for (int j = 0; j < k; j++)
          if ((((gx[j] ^ gx[k]) & m) == 0) && (((gy[j] ^ gy[k]) & m) == 0)) dupe = 1'b1;
        if (!dupe) begin
          v = {32'(gx[k] & m), 32'(gy[k] & m)};
          case (id)
            0:       qa.push_back(v);
            1:       qb.push_back(v);
            default: qc.push_back(v);
          endcase
        end
      end
      if (y < x) break;
      if (d > 0) begin d = d + 4 * ((x + 1) - (y - 1)) + 10; y = y - 1; end
      else             d = d + 4 * (x + 1) + 6;
      x = x + 1;
    end
  endtask

  logic        a_hold;
  logic [63:0] a_held, ea, eb, ec;

  always @(negedge clk) begin
    if (rst_n) begin
      if (va && ready) begin
        if (qa.size() == 0) chk("a_extra_point", {oa0, oa1}, 64'h0 - 1);
        else begin ea = qa.pop_front(); chk("a_point", {oa0, oa1}, ea); end
      end
      if (a_hold) begin
        chk("a_stall_valid", {63'b0, va}, 64'd1);
        chk("a_stall_data", {oa0, oa1}, a_held);
      end
      a_hold = va && !ready;
      a_held = {oa0, oa1};
    end else a_hold = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n && vb && ready) begin
      if (qb.size() == 0) chk("b_extra_point", {ob0, ob1}, 64'h0 - 1);
      else begin eb = qb.pop_front(); chk("b_point", {ob0, ob1}, eb); end
    end
  end

  always @(negedge clk) begin
    if (rst_n && vc && ready) begin
      if (qc.size() == 0) chk("c_extra_point", {24'b0, oc0, 24'b0, oc1}, 64'h0 - 1);
      else begin ec = qc.pop_front(); chk("c_point", {24'b0, oc0, 24'b0, oc1}, ec); end
    end
  end

  // mode: 0 ready held high, 1 toggling, 2 random. Returns cycle in which A shows done.
  task automatic run(input logic [31:0] x0, input logic [31:0] y0, input logic [31:0] rr,
                     input int mode, input bit pulse, output int na);
    int n;
    model($signed(x0), $signed(y0), $signed(rr), 32, 1'b0, 0);
    model($signed(x0), $signed(y0), $signed(rr), 32, 1'b1, 1);
    @(negedge clk);
    start = 1'b1; cx = x0; cy = y0; r = rr;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; na = 0;
    while (n < 3000) begin
      @(negedge clk); n++;
      if (done_a && na == 0) na = n;
      if (done_a && done_b) break;
      start = pulse && (n == 5);
      if (start) begin cx = x0 + 32'd7; r = rr + 32'd2; end
      @(posedge clk); #1;
      if (mode == 1)      ready = ~ready;
      else if (mode == 2) ready = 1'($urandom_range(0, 1));
      else                ready = 1'b1;
    end
    ready = 1'b1;
    chk("ab_done_reached", {62'b0, done_a, done_b}, 64'd3);
    chk("ab_idle_after", {62'b0, busy_a, busy_b}, 64'd0);
    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_queue_drained", 64'(qb.size()), 64'd0);
    qa.delete(); qb.delete();
  endtask

  task automatic run8(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] rr);
    int n;
    model($signed(x0), $signed(y0), $signed(rr), 8, 1'b0, 2);
    ready = 1'b1;
    @(negedge clk);
    start8 = 1'b1; cx8 = x0; cy8 = y0; r8 = rr;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (n < 3000 && !done_c) begin @(negedge clk); n++; end
    chk("c_done_reached", {63'b0, done_c}, 64'd1);
    chk("c_queue_drained", 64'(qc.size()), 64'd0);
    qc.delete();
  endtask

  initial begin
    int na, n;
    rst_n = 1'b1; start = 1'b0; start8 = 1'b0; ready = 1'b1;
    cx = '0; cy = '0; r = '0; cx8 = '0; cy8 = '0; r8 = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("reset_outputs_a", {va, busy_a, done_a, oa0, oa1}, 67'h0);
    chk("reset_outputs_c", {vc, busy_c, done_c, oc0, oc1}, 64'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run(32'd5, 32'd5, 32'd0, 0, 1'b0, na);
    chk("r0_done_cycle", 64'(na), 64'd18);
    run(32'd0, 32'd0, 32'd3, 0, 1'b0, na);
    chk("r3_done_cycle", 64'(na), 64'd36);
    run(32'd0, 32'd0, 32'd3, 1, 1'b0, na);
    run(32'd10, 32'hFFFF_FFF0, 32'd6, 0, 1'b1, na);
    run(32'd1, 32'd2, 32'hFFFF_FFFE, 0, 1'b0, na);

    // Asynchronous reset while the second group is in flight.
    model(0, 0, 3, 32, 1'b0, 0);
    model(0, 0, 3, 32, 1'b1, 1);
    @(negedge clk);
    start = 1'b1; cx = '0; cy = '0; r = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (qa.size() > 20 && n < 500) begin @(negedge clk); n++; end
    chk("mid_group2_reached", {63'b0, busy_a}, 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_a", {va, busy_a, done_a, oa0, oa1}, 67'h0);
    chk("midrun_reset_b", {vb, busy_b, done_b, ob0, ob1}, 67'h0);
    qa.delete(); qb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run(32'd0, 32'd0, 32'd3, 0, 1'b0, na);
    chk("restart_done_cycle", 64'(na), 64'd36);

    run8(8'd127, 8'd0, 8'd1);
    run8(8'd120, 8'd250, 8'd9);

    for (int i = 0; i < 8; i++) begin
      run($urandom, $urandom, 32'($urandom_range(0, 28)) - 32'd3, i % 3, i[0], na);
      run8(8'($urandom), 8'($urandom), 8'($urandom_range(0, 22)) - 8'd2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
